tick_irq_gen: RTL and testbench

- Multi-channel, multi-level periodic interrupt generator.
- Next generation of the fixed 15 Hz PicoBlaze interrupt source; sits between the system clock domain and the PicoBlaze `interrupt`/`interrupt_ack` pins.
- One shared period counter, with its rate selectable at run time across NUM_LEVELS speed levels; this drives game-speed increases.
- Each channel holds its interrupt pending until the processor acknowledges it, and flags missed periods as overruns.

---
 rtl/tick_irq_pkg.sv | 46 ++++
 rtl/tick_irq_gen_irq_channel.sv | 48 ++++
 rtl/tick_irq_gen.sv | 95 +++++++++
 tb/tb_tick_irq_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_irq_pkg.sv
// Shared helpers for tick_irq_gen: level-width derivation, per-level top counts
// and the elaboration-time sanity check of a parameter set.
package tick_irq_pkg;

  function automatic int unsigned lvl_width(input int unsigned num_levels);
    return (num_levels <= 2) ? 1 : $clog2(num_levels);
  endfunction

  // Last count value of a period at the given level; the period is top+1 cycles.
  function automatic longint unsigned top_count(
    input int unsigned     level,
    input bit              sim,
    input longint unsigned clk_hz,
    input longint unsigned base_hz,
    input longint unsigned step_hz,
    input longint unsigned sim_cnt
  );
    longint unsigned rate;
    rate = base_hz + longint'(level) * step_hz;
    if (sim) return sim_cnt >> level;
    if (rate == 0 || clk_hz / rate < 2) return 0;
    return clk_hz / rate - 1;
  endfunction

  // True when every level yields a nonzero top count that fits the counter.
  function automatic bit config_ok(
    input int unsigned     num_levels,
    input int unsigned     num_channels,
    input int unsigned     cntr_width,
    input bit              sim,
    input longint unsigned clk_hz,
    input longint unsigned base_hz,
    input longint unsigned step_hz,
    input longint unsigned sim_cnt
  );
    longint unsigned t;
    if (num_levels < 1 || num_channels < 1 || cntr_width < 1) return 0;
    for (int unsigned l = 0; l < num_levels; l++) begin
      t = top_count(l, sim, clk_hz, base_hz, step_hz, sim_cnt);
      if (t == 0) return 0;
      if (cntr_width < 64 && (t >> cntr_width) != 0) return 0;
    end
    return 1;
  endfunction

endpackage

// File: rtl/tick_irq_gen_irq_channel.sv
// One interrupt channel: a pending request held until acknowledged, plus a
// sticky overrun flag raised when a tick finds the previous request unserved.
module irq_channel
  import tick_irq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic enable_i,
  input  logic irq_ack_i,
  input  logic overrun_clr_i,
  output logic pending_o,
  output logic overrun_o
);

  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic ovr_set;

  // An ack arriving with the tick consumes the old request, so no overrun.
  assign ovr_set = enable_i && tick_i && pending_q && !irq_ack_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!enable_i)      pending_d = 1'b0;
    else if (tick_i)    pending_d = 1'b1;
    else if (irq_ack_i) pending_d = 1'b0;
    if (ovr_set)            overrun_d = 1'b1;
    else if (overrun_clr_i) overrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/tick_irq_gen.sv
// Multi-channel periodic interrupt generator for the PicoBlaze: one shared
// period counter at a run-time speed level, and per-channel pending/overrun state.
module tick_irq_gen
  import tick_irq_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned BASE_FREQUENCY_HZ      = 15,
  parameter int unsigned LEVEL_STEP_HZ          = 5,
  parameter int unsigned NUM_LEVELS             = 4,
  parameter int unsigned NUM_CHANNELS           = 2,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter bit          SIMULATE               = 1'b0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 15,
  localparam int unsigned LVL_W                 = lvl_width(NUM_LEVELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LVL_W-1:0]        level,
  input  logic                    level_load,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] irq_ack,
  input  logic [NUM_CHANNELS-1:0] overrun_clr,
  output logic [NUM_CHANNELS-1:0] sys_interrupt,
  output logic                    tick,
  output logic [NUM_CHANNELS-1:0] overrun,
  output logic [LVL_W-1:0]        cur_level
);

  localparam logic [LVL_W-1:0] MAX_LEVEL = LVL_W'(NUM_LEVELS - 1);

  if (!config_ok(NUM_LEVELS, NUM_CHANNELS, CNTR_WIDTH, SIMULATE,
                 longint'(CLK_FREQUENCY_HZ), longint'(BASE_FREQUENCY_HZ),
                 longint'(LEVEL_STEP_HZ), longint'(SIMULATE_FREQUENCY_CNT))) begin : g_bad_cfg
    $error("tick_irq_gen: a level has a zero top count or one too wide for CNTR_WIDTH");
  end

  logic [CNTR_WIDTH-1:0] top_tbl [NUM_LEVELS];

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_top
    localparam longint unsigned TOP = top_count(l, SIMULATE,
      longint'(CLK_FREQUENCY_HZ), longint'(BASE_FREQUENCY_HZ),
      longint'(LEVEL_STEP_HZ), longint'(SIMULATE_FREQUENCY_CNT));
    assign top_tbl[l] = CNTR_WIDTH'(TOP);
  end

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic [LVL_W-1:0]      cur_level_q, cur_level_d;
  logic [LVL_W-1:0]      shadow_q, shadow_d;
  logic [LVL_W-1:0]      level_sat;
  logic                  wrap;

  assign level_sat = (level > MAX_LEVEL) ? MAX_LEVEL : level;
  assign wrap      = (cnt_q == top_tbl[cur_level_q]);

  // The shadow only takes effect at a boundary, so a period always finishes at its starting rate.
  always_comb begin
    cnt_d       = wrap ? '0 : cnt_q + CNTR_WIDTH'(1);
    tick_d      = wrap;
    cur_level_d = wrap ? shadow_q : cur_level_q;
    shadow_d    = level_load ? level_sat : shadow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      cur_level_q <= '0;
      shadow_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      cur_level_q <= cur_level_d;
      shadow_q    <= shadow_d;
    end
  end

  // Channels see the wrap condition so their pending flop rises with tick.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    irq_channel u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick_i       (wrap),
      .enable_i     (enable[i]),
      .irq_ack_i    (irq_ack[i]),
      .overrun_clr_i(overrun_clr[i]),
      .pending_o    (sys_interrupt[i]),
      .overrun_o    (overrun[i])
    );
  end

  assign tick      = tick_q;
  assign cur_level = cur_level_q;

endmodule

// File: tb/tb_tick_irq_gen.sv
// Self-checking bench for tick_irq_gen in simulation mode (top(L) = 15 >> L):
// a countdown-based reference model checked every cycle plus directed timing checks.
module tb_tick_irq_gen;

  localparam int NL      = 4;
  localparam int NC      = 2;
  localparam int SIM_CNT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    level = '0;
  logic          level_load = 1'b0;
  logic [NC-1:0] enable = '0;
  logic [NC-1:0] irq_ack = '0;
  logic [NC-1:0] overrun_clr = '0;
  logic [NC-1:0] sys_interrupt;
  logic          tick;
  logic [NC-1:0] overrun;
  logic [1:0]    cur_level;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  tick_irq_gen #(
    .CLK_FREQUENCY_HZ      (100000000),
    .BASE_FREQUENCY_HZ     (15),
    .LEVEL_STEP_HZ         (5),
    .NUM_LEVELS            (NL),
    .NUM_CHANNELS          (NC),
    .CNTR_WIDTH            (32),
    .SIMULATE              (1'b1),
    .SIMULATE_FREQUENCY_CNT(SIM_CNT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level        (level),
    .level_load   (level_load),
    .enable       (enable),
    .irq_ack      (irq_ack),
    .overrun_clr  (overrun_clr),
    .sys_interrupt(sys_interrupt),
    .tick         (tick),
    .overrun      (overrun),
    .cur_level    (cur_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts down the cycles left in the current period.
  function automatic int m_top(input int l);
    return SIM_CNT / (1 << l);
  endfunction

  int            m_lvl, m_shadow, m_left, sh_next;
  bit            m_tick, wrap;
  logic [NC-1:0] m_pend, m_ovr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lvl = 0; m_shadow = 0; m_left = m_top(0) + 1;
      m_tick = 0; m_pend = '0; m_ovr = '0;
    end else begin
      m_left  = m_left - 1;
      wrap    = (m_left == 0);
      sh_next = level_load ? ((int'(level) > NL - 1) ? NL - 1 : int'(level)) : m_shadow;
      if (wrap) begin
        m_lvl  = m_shadow;
        m_left = m_top(m_lvl) + 1;
      end
      m_shadow = sh_next;
      m_tick   = wrap;
      for (int i = 0; i < NC; i++) begin
        if (enable[i] && wrap && m_pend[i] && !irq_ack[i]) m_ovr[i] = 1'b1;
        else if (overrun_clr[i])                           m_ovr[i] = 1'b0;
        if (!enable[i])      m_pend[i] = 1'b0;
        else if (wrap)       m_pend[i] = 1'b1;
        else if (irq_ack[i]) m_pend[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tick", tick, m_tick);
      check("model_sys_interrupt", sys_interrupt, m_pend);
      check("model_overrun", overrun, m_ovr);
      check("model_cur_level", cur_level, m_lvl[1:0]);
    end
  end

  // Advances negedge by negedge until tick is seen; returns the cycles waited.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (tick !== 1'b1 && cycles < 200);
    if (tick !== 1'b1) check("tick_timeout", tick, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int c;

  initial begin
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sys_interrupt", sys_interrupt, 0);
    check("reset_tick", tick, 0);
    check("reset_overrun", overrun, 0);
    check("reset_cur_level", cur_level, 0);

    reset  = 1'b0;
    enable = 2'b11;
    wait_tick(c);
    check("first_period", c, 16);
    check("both_rise_with_tick", sys_interrupt, 2'b11);

    irq_ack = 2'b01;
    @(negedge clk);
    irq_ack = 2'b00;
    check("ack0_only", sys_interrupt, 2'b10);
    wait_tick(c);
    check("second_period", 1 + c, 16);
    check("overrun1_after_two_ticks", overrun, 2'b10);

    irq_ack = 2'b11;
    @(negedge clk);
    irq_ack = 2'b00;
    check("overrun_sticky_over_ack", overrun, 2'b10);
    check("acks_clear_pending", sys_interrupt, 2'b00);
    overrun_clr = 2'b10;
    @(negedge clk);
    overrun_clr = 2'b00;
    check("overrun_clr1", overrun, 2'b00);

    wait_tick(c);
    check("third_period", 2 + c, 16);
    repeat (15) @(negedge clk);
    irq_ack = 2'b11;
    @(negedge clk);
    irq_ack = 2'b00;
    check("coincident_tick", tick, 1);
    check("coincident_pending", sys_interrupt, 2'b11);
    check("coincident_no_overrun", overrun, 2'b00);

    repeat (5) @(negedge clk);
    level      = 2'd2;
    level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
    check("level_not_yet_applied", cur_level, 0);
    wait_tick(c);
    check("period_at_old_rate", 6 + c, 16);
    check("level2_applied", cur_level, 2);
    wait_tick(c);
    check("period_level2", c, 4);

    level      = 2'(7);
    level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
    wait_tick(c);
    check("period_finish_level2", 1 + c, 4);
    check("level_saturated", cur_level, 3);
    wait_tick(c);
    check("period_level3", c, 2);

    enable = 2'b01;
    @(negedge clk);
    check("disable_drops_irq1", sys_interrupt[1], 0);
    wait_tick(c);
    wait_tick(c);
    check("tick_ungated", c, 2);
    check("disabled_stays_low", sys_interrupt[1], 0);

    level       = 2'd0;
    level_load  = 1'b1;
    overrun_clr = 2'b11;
    @(negedge clk);
    level_load  = 1'b0;
    overrun_clr = 2'b00;
    wait_tick(c);
    check("back_to_level0", cur_level, 0);
    enable = 2'b11;
    wait_tick(c);
    check("period_level0_again", c, 16);
    check("pending_before_reset", sys_interrupt, 2'b11);

    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_sys_interrupt", sys_interrupt, 0);
    check("async_reset_overrun", overrun, 0);
    check("async_reset_tick", tick, 0);
    check("async_reset_cur_level", cur_level, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_tick(c);
    check("period_after_reset", c, 16);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
